// File: rtl/sva_chk_pkg.sv
// Shared types and the per-slot step function for the bounded-delay checkers.
// Thread ages are carried at a fixed package width; each checker narrows to its own AGE_WIDTH.
package sva_chk_pkg;

  localparam int unsigned THR_AGE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SPAWN = 2'd2
  } ctrl_fsm_t;

  typedef struct packed {
    logic                 active;
    logic [THR_AGE_W-1:0] age;
  } thread_t;

  typedef struct packed {
    thread_t              thread;
    logic                 succ;
    logic                 fail;
    logic [THR_AGE_W-1:0] age;
  } thread_res_t;

  // Advance one live attempt by one gclk tick: pass, expire, or keep ageing.
  function automatic thread_res_t next_thread(
    input thread_t              t,
    input logic                 b_s,
    input logic [THR_AGE_W-1:0] min_dly,
    input logic [THR_AGE_W-1:0] max_dly
  );
    thread_res_t          r;
    logic [THR_AGE_W-1:0] age_n;
    r        = '0;
    r.thread = t;
    age_n    = t.age + THR_AGE_W'(1);
    if (t.active) begin
      if (b_s && (age_n >= min_dly)) begin
        r.succ   = 1'b1;
        r.age    = age_n;
        r.thread = '0;
      end else if (age_n == max_dly) begin
        r.fail   = 1'b1;
        r.age    = age_n;
        r.thread = '0;
      end else begin
        r.thread.age = age_n;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sva_delay_checker_edge_det.sv
// Two-flop rising-edge detector for a slow user clock sampled as data.
// A synchronous clear drops both flops so a held-high input re-arms after clr.
module sva_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic tick_c
);

  logic g0;
  logic g1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g0 <= 1'b0;
      g1 <= 1'b0;
    end else if (clr) begin
      g0 <= 1'b0;
      g1 <= 1'b0;
    end else begin
      g0 <= d;
      g1 <= g0;
    end
  end

  assign tick_c = g0 & ~g1;

endmodule

// File: rtl/sva_delay_checker.sv
// Multi-thread checker for a |-> ##[MIN_DLY:MAX_DLY] b, sampled on gclk edges seen in sys_clk.
// Each gclk tick scans every slot once, then spawns a new attempt if a was high.
module sva_delay_checker #(
  parameter int unsigned MIN_DLY     = 1,
  parameter int unsigned MAX_DLY     = 4,
  parameter int unsigned MAX_THREADS = 4,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned AGE_WIDTH   = $clog2(MAX_DLY + 1)
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               grst,
  input  logic                               gclk,
  input  logic                               a,
  input  logic                               b,
  output logic                               busy,
  output logic                               succ,
  output logic [AGE_WIDTH-1:0]               succ_age,
  output logic                               fail,
  output logic                               overflow,
  output logic                               tick_overrun,
  output logic [$clog2(MAX_THREADS+1)-1:0]   active_cnt,
  output logic [CNT_WIDTH-1:0]               succ_cnt,
  output logic [CNT_WIDTH-1:0]               fail_cnt
);

  import sva_chk_pkg::*;

  localparam int unsigned ACT_W = $clog2(MAX_THREADS + 1);
  localparam int unsigned IDX_W = (MAX_THREADS > 1) ? $clog2(MAX_THREADS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(MAX_THREADS - 1);
  localparam logic [THR_AGE_W-1:0] MIN_A    = THR_AGE_W'(MIN_DLY);
  localparam logic [THR_AGE_W-1:0] MAX_A    = THR_AGE_W'(MAX_DLY);
  localparam logic [THR_AGE_W-1:0] AGE_LIM  = THR_AGE_W'((2 ** AGE_WIDTH) - 1);

  ctrl_fsm_t        state_q;
  ctrl_fsm_t        state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  logic tick_c;
  logic capture_c;
  logic scan_c;
  logic spawn_c;
  logic overrun_c;

  logic a_s;
  logic b_s;

  thread_t          slots_q [MAX_THREADS];
  thread_res_t      res_c;
  logic             free_found_c;
  logic [IDX_W-1:0] free_idx_c;
  logic [AGE_WIDTH-1:0] succ_age_c;

  sva_edge_det u_edge (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    (grst),
    .d      (gclk),
    .tick_c (tick_c)
  );

  // FSM state register; busy mirrors the registered state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Next-state logic; grst forces IDLE regardless of scan progress.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (grst) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick_c) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
        SCAN: begin
          if (idx_q == LAST_IDX) begin
            state_d = SPAWN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        SPAWN:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM strobes driving the slot datapath.
  always_comb begin
    capture_c = 1'b0;
    scan_c    = 1'b0;
    spawn_c   = 1'b0;
    overrun_c = 1'b0;
    if (!grst) begin
      capture_c = (state_q == IDLE) && tick_c;
      scan_c    = (state_q == SCAN);
      spawn_c   = (state_q == SPAWN);
      overrun_c = (state_q != IDLE) && tick_c;
    end
  end

  // Lowest-numbered free slot for the next spawn.
  always_comb begin
    free_found_c = 1'b0;
    free_idx_c   = '0;
    for (int unsigned i = MAX_THREADS; i > 0; i--) begin
      if (!slots_q[i-1].active) begin
        free_found_c = 1'b1;
        free_idx_c   = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    res_c      = next_thread(slots_q[idx_q], b_s, MIN_A, MAX_A);
    succ_age_c = (res_c.age > AGE_LIM) ? '1 : AGE_WIDTH'(res_c.age);
  end

  // Slot table, pulses, counters and sticky flags.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int unsigned i = 0; i < MAX_THREADS; i++) slots_q[i] <= '0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      succ         <= 1'b0;
      succ_age     <= '0;
      fail         <= 1'b0;
      overflow     <= 1'b0;
      tick_overrun <= 1'b0;
      active_cnt   <= '0;
      succ_cnt     <= '0;
      fail_cnt     <= '0;
    end else if (grst) begin
      // Counters and sticky flags survive a user reset.
      for (int unsigned i = 0; i < MAX_THREADS; i++) slots_q[i] <= '0;
      a_s        <= 1'b0;
      b_s        <= 1'b0;
      succ       <= 1'b0;
      fail       <= 1'b0;
      active_cnt <= '0;
    end else begin
      succ <= scan_c & res_c.succ;
      fail <= scan_c & res_c.fail;
      if (capture_c) begin
        a_s <= a;
        b_s <= b;
      end
      if (overrun_c) tick_overrun <= 1'b1;
      if (scan_c) begin
        slots_q[idx_q] <= res_c.thread;
        if (res_c.succ || res_c.fail) active_cnt <= active_cnt - ACT_W'(1);
        if (res_c.succ) begin
          succ_age <= succ_age_c;
          if (succ_cnt != '1) succ_cnt <= succ_cnt + CNT_WIDTH'(1);
        end
        if (res_c.fail && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_WIDTH'(1);
      end
      if (spawn_c && a_s) begin
        if (free_found_c) begin
          slots_q[free_idx_c] <= '{active: 1'b1, age: '0};
          active_cnt          <= active_cnt + ACT_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
